// File: rtl/motor_segment_sequencer_pkg.sv
// Shared widths, segment record and sequencer state encoding for the motor axis sequencer.
// The DIR_SETUP state exists only when MOTOR_DIR_SETUP_EN is defined.
package motor_ctrl_pkg;

  localparam int DIV_W   = 15;
  localparam int STEPS_W = 14;
  localparam int POS_W   = 19;

  typedef struct packed {
    logic               dir;
    logic [DIV_W-1:0]   divider;
    logic [STEPS_W-1:0] steps;
  } segmentT;

`ifdef MOTOR_DIR_SETUP_EN
  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    DIR_SETUP  = 3'd1,
    LOAD       = 3'd2,
    WAIT_START = 3'd3,
    RUN        = 3'd4
  } seqStateT;
`else
  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    LOAD       = 3'd2,
    WAIT_START = 3'd3,
    RUN        = 3'd4
  } seqStateT;
`endif

endpackage

// File: rtl/motor_segment_sequencer_if.sv
// Host-side segment write channel between the command decoder and the sequencer.
interface motor_segment_sequencer_if;
  // A segment transfers on every rising CLK edge where wrValid && wrReady; the host holds
  // the payload stable while wrValid is high, and wrReady does not depend on wrValid.
  logic                             wrValid;
  logic                             wrReady;
  logic                             wrDir;
  logic [motor_ctrl_pkg::DIV_W-1:0]   wrDivider;
  logic [motor_ctrl_pkg::STEPS_W-1:0] wrSteps;

  modport master (output wrValid, wrDir, wrDivider, wrSteps, input wrReady);
  modport slave  (input wrValid, wrDir, wrDivider, wrSteps, output wrReady);
endinterface

// File: rtl/motor_segment_sequencer_seg_fifo.sv
// DEPTH-entry synchronous segment queue with occupancy count and single-cycle flush.
module seg_fifo
  import motor_ctrl_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                     CLK,
  input  logic                     nReset,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  segmentT                  din,
  output segmentT                  dout,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

  segmentT         mem [DEPTH];
  logic [AW-1:0]   rdPtr;
  logic [AW-1:0]   wrPtr;
  logic            doPush;
  logic            doPop;

  assign full   = (count == FULL_COUNT);
  assign empty  = (count == '0);
  assign doPush = push && !full;
  assign doPop  = pop && !empty;
  assign dout   = mem[rdPtr];

  always_ff @(posedge CLK or negedge nReset) begin
    if (!nReset) begin
      rdPtr <= '0;
      wrPtr <= '0;
      count <= '0;
    end else if (flush) begin
      // flush beats any same-cycle push or pop
      rdPtr <= '0;
      wrPtr <= '0;
      count <= '0;
    end else begin
      if (doPush) wrPtr <= wrPtr + 1'b1;
      if (doPop)  rdPtr <= rdPtr + 1'b1;
      case ({doPush, doPop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (doPush && !flush) mem[wrPtr] <= din;
  end

endmodule

// File: rtl/motor_segment_sequencer.sv
// Per-axis segment sequencer: queues host segments, loads them into the step generator, tracks position.
// Optional direction setup delay is enabled by defining MOTOR_DIR_SETUP_EN.
module motor_segment_sequencer
  import motor_ctrl_pkg::*;
#(
  parameter int DEPTH          = 8,
  parameter int DIR_SETUP_CLKS = 50
) (
  input  logic                         CLK,
  input  logic                         nReset,
  motor_segment_sequencer_if.slave     wr,
  input  logic                         flush,
  input  logic                         posClear,
  input  logic                         genBusy,
  input  logic                         genStep,
  output logic                         segDir,
  output logic [DIV_W-1:0]             segDivider,
  output logic [STEPS_W-1:0]           segSteps,
  output logic                         segDone,
  output logic                         running,
  output logic [$clog2(DEPTH):0]       fifoCount,
  output logic signed [POS_W-1:0]      position,
  output seqStateT                     dbgState
);
  seqStateT         state;
  seqStateT         stateNext;
  segmentT          head;
  segmentT          held;
  segmentT          wrSeg;
  logic             fifoFull;
  logic             fifoEmpty;
  logic             pop;
  logic             loadHeld;
  logic             doneNext;
  logic             genStepQ;
  logic [POS_W-1:0] pos;

  assign wrSeg = '{dir: wr.wrDir, divider: wr.wrDivider, steps: wr.wrSteps};
  assign wr.wrReady = !fifoFull;
  assign pop = (state == IDLE) && !fifoEmpty;

  seg_fifo #(.DEPTH(DEPTH)) u_fifo (
    .CLK    (CLK),
    .nReset (nReset),
    .push   (wr.wrValid),
    .pop    (pop),
    .flush  (flush),
    .din    (wrSeg),
    .dout   (head),
    .count  (fifoCount),
    .full   (fifoFull),
    .empty  (fifoEmpty)
  );

`ifdef MOTOR_DIR_SETUP_EN
  localparam int CW = $clog2(DIR_SETUP_CLKS + 1);
  logic [CW-1:0] setupCnt;

  always_ff @(posedge CLK or negedge nReset) begin
    if (!nReset)                 setupCnt <= '0;
    else if (state != DIR_SETUP) setupCnt <= '0;
    else                         setupCnt <= setupCnt + 1'b1;
  end
`endif

  always_ff @(posedge CLK or negedge nReset) begin
    if (!nReset) begin
      state    <= IDLE;
      held     <= '0;
      segDone  <= 1'b0;
      genStepQ <= 1'b0;
      pos      <= '0;
    end else begin
      state    <= stateNext;
      segDone  <= doneNext;
      genStepQ <= genStep;
      if (loadHeld) held <= head;
      if (posClear)
        pos <= '0;
      else if (genStep && !genStepQ)
        pos <= pos + (held.dir ? POS_W'(1) : {POS_W{1'b1}});
    end
  end

  always_comb begin
    stateNext = state;
    doneNext  = 1'b0;
    loadHeld  = 1'b0;
    case (state)
      IDLE: begin
        if (!fifoEmpty) begin
          // zero-step segments retire immediately and never touch the held segment
          if (head.steps == '0) begin
            doneNext = 1'b1;
          end else begin
            loadHeld = 1'b1;
`ifdef MOTOR_DIR_SETUP_EN
            if (head.dir != held.dir) stateNext = DIR_SETUP;
            else                      stateNext = LOAD;
`else
            stateNext = LOAD;
`endif
          end
        end
      end
`ifdef MOTOR_DIR_SETUP_EN
      DIR_SETUP:  if (setupCnt == CW'(DIR_SETUP_CLKS - 1)) stateNext = LOAD;
`endif
      LOAD:       stateNext = WAIT_START;
      WAIT_START: if (genBusy) stateNext = RUN;
      RUN: begin
        if (!genBusy) begin
          doneNext  = 1'b1;
          stateNext = IDLE;
        end
      end
      default:    stateNext = IDLE;
    endcase
  end

  assign segDir     = held.dir;
  assign segDivider = held.divider;
  assign segSteps   = (state == LOAD) ? held.steps : '0;
  assign running    = (state != IDLE);
  assign position   = pos;
  assign dbgState   = state;

endmodule

// File: tb/tb_motor_segment_sequencer.sv
// Scoreboard bench for motor_segment_sequencer with a behavioural step generator model.
module tb_motor_segment_sequencer;
  import motor_ctrl_pkg::*;

  localparam int DEPTH      = 8;
  localparam int SETUP_CLKS = 50;

  logic                  CLK;
  logic                  nReset;
  logic                  flush;
  logic                  posClear;
  logic                  genBusy;
  logic                  genStep;
  logic                  segDir;
  logic [DIV_W-1:0]      segDivider;
  logic [STEPS_W-1:0]    segSteps;
  logic                  segDone;
  logic                  running;
  logic [$clog2(DEPTH):0] fifoCount;
  logic signed [POS_W-1:0] position;
  seqStateT              dbgState;

  motor_segment_sequencer_if wrIf ();

  motor_segment_sequencer #(.DEPTH(DEPTH), .DIR_SETUP_CLKS(SETUP_CLKS)) dut (
    .CLK        (CLK),
    .nReset     (nReset),
    .wr         (wrIf.slave),
    .flush      (flush),
    .posClear   (posClear),
    .genBusy    (genBusy),
    .genStep    (genStep),
    .segDir     (segDir),
    .segDivider (segDivider),
    .segSteps   (segSteps),
    .segDone    (segDone),
    .running    (running),
    .fifoCount  (fifoCount),
    .position   (position),
    .dbgState   (dbgState)
  );

  int vectors     = 0;
  int miscompares = 0;
  logic [29:0] exp_q[$];
  int doneSeen    = 0;
  int dirStable   = 0;
  logic prevDirSample = 1'b0;
  logic prevLoadDir   = 1'b0;
  logic [POS_W-1:0] expPos = '0;
  logic genHold;

  // clock / reset
  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // behavioural step generator: one step every 'divider' cycles, busy until steps run out
  int remSteps;
  int divCnt;
  int curDiv;
  always @(posedge CLK or negedge nReset) begin
    if (!nReset) begin
      genBusy  <= 1'b0;
      genStep  <= 1'b0;
      remSteps <= 0;
      divCnt   <= 0;
      curDiv   <= 0;
    end else begin
      genStep <= 1'b0;
      if (segSteps != '0 && !genBusy) begin
        genBusy  <= 1'b1;
        remSteps <= int'(segSteps);
        divCnt   <= int'(segDivider);
        curDiv   <= int'(segDivider);
      end else if (genBusy) begin
        if (remSteps == 0) begin
          if (!genHold) genBusy <= 1'b0;
        end else if (divCnt <= 1) begin
          genStep  <= 1'b1;
          remSteps <= remSteps - 1;
          divCnt   <= curDiv;
        end else begin
          divCnt <= divCnt - 1;
        end
      end
    end
  end

  // monitor / scoreboard
  always @(negedge CLK) begin
    if (!nReset) begin
      prevDirSample = 1'b0;
      prevLoadDir   = 1'b0;
      dirStable     = 0;
    end else begin
      if (segDir !== prevDirSample) dirStable = 0;
      else                          dirStable++;
      prevDirSample = segDir;
      if (segDone === 1'b1) doneSeen++;
      if (segSteps != '0) begin
        if (exp_q.size() == 0) check("unexpected load", 1, 0);
        else check("load segment", {segDir, segDivider, segSteps}, exp_q.pop_front());
        if (segDir != prevLoadDir) begin
`ifdef MOTOR_DIR_SETUP_EN
          check("dir setup >= 50", (dirStable >= SETUP_CLKS) ? 1 : 0, 1);
`else
          check("dir change no gap", dirStable, 0);
`endif
        end
        prevLoadDir = segDir;
      end
    end
  end

  // driver tasks
  task automatic pushSeg(input logic dir, input int div, input int steps, input bit expectLoad);
    wrIf.wrValid   = 1'b1;
    wrIf.wrDir     = dir;
    wrIf.wrDivider = DIV_W'(div);
    wrIf.wrSteps   = STEPS_W'(steps);
    if (expectLoad) exp_q.push_back({dir, DIV_W'(div), STEPS_W'(steps)});
    @(posedge CLK); #1;
    wrIf.wrValid = 1'b0;
  endtask

  task automatic waitIdle(input string name, input int budget);
    int n;
    n = 0;
    repeat (2) begin @(posedge CLK); #1; end
    while ((running || fifoCount != 0 || genBusy) && n < budget) begin
      @(posedge CLK); #1;
      n++;
    end
    if (n >= budget) check({name, " idle timeout"}, 1, 0);
    repeat (2) begin @(posedge CLK); #1; end
  endtask

  task automatic waitRunEmpty(input string name);
    int n;
    n = 0;
    while (!(running && fifoCount == 0 && genBusy) && n < 200) begin
      @(posedge CLK); #1;
      n++;
    end
    if (n >= 200) check({name, " run timeout"}, 1, 0);
  endtask

  int doneBase;

  initial begin
    nReset = 1'b0; flush = 1'b0; posClear = 1'b0; genHold = 1'b0;
    wrIf.wrValid = 1'b1; wrIf.wrDir = 1'b1; wrIf.wrDivider = 15'd7; wrIf.wrSteps = 14'd3;

    // 1. reset with push attempts
    repeat (4) @(posedge CLK);
    #1;
    check("reset fifoCount", fifoCount, 0);
    check("reset position", position, 0);
    check("reset running", running, 0);
    check("reset wrReady", wrIf.wrReady, 1);
    check("reset segSteps", segSteps, 0);
    check("reset state", dbgState, IDLE);
    wrIf.wrValid = 1'b0;
    @(negedge CLK); nReset = 1'b1;
    @(posedge CLK); #1;

    // 2. single segment
    doneBase = doneSeen;
    pushSeg(1'b1, 100, 10, 1'b1);
    waitIdle("single", 3000);
    expPos = expPos + 19'd10;
    check("single position", position, expPos);
    check("single segDone", doneSeen - doneBase, 1);

    // 3. fill FIFO with the generator held busy
    doneBase = doneSeen;
    genHold = 1'b1;
    pushSeg(1'b1, 2, 2, 1'b1);
    waitRunEmpty("fill");
    for (int i = 0; i < 9; i++) begin
      check("fill wrReady", wrIf.wrReady, (i < DEPTH) ? 1 : 0);
      pushSeg(1'b1, 3 + i, i + 1, i < DEPTH);
    end
    check("fill fifoCount", fifoCount, DEPTH);
    check("fill wrReady full", wrIf.wrReady, 0);
    genHold = 1'b0;
    waitIdle("fill", 3000);
    expPos = expPos + 19'd38;
    check("fill position", position, expPos);
    check("fill segDone", doneSeen - doneBase, 9);

    // 4. zero-step segment between two real ones
    doneBase = doneSeen;
    pushSeg(1'b1, 3, 5, 1'b1);
    pushSeg(1'b1, 3, 0, 1'b0);
    pushSeg(1'b1, 3, 5, 1'b1);
    waitIdle("zero", 2000);
    expPos = expPos + 19'd10;
    check("zero position", position, expPos);
    check("zero segDone", doneSeen - doneBase, 3);

    // 5. direction reversal after a position clear
    posClear = 1'b1;
    @(posedge CLK); #1;
    posClear = 1'b0;
    expPos = '0;
    check("posClear idle", position, 0);
    doneBase = doneSeen;
    pushSeg(1'b1, 2, 4, 1'b1);
    pushSeg(1'b0, 2, 4, 1'b1);
    waitIdle("reversal", 2000);
    check("reversal position", position, expPos);
    check("reversal segDone", doneSeen - doneBase, 2);

    // 6a. posClear coincident with a step edge
    doneBase = doneSeen;
    pushSeg(1'b1, 4, 6, 1'b1);
    begin
      int n;
      n = 0;
      while (!genStep && n < 300) begin @(posedge CLK); #1; n++; end
      if (n >= 300) check("posClear step timeout", 1, 0);
    end
    posClear = 1'b1;
    @(posedge CLK); #1;
    posClear = 1'b0;
    check("posClear on edge", position, 0);
    waitIdle("posClear", 500);
    expPos = 19'd5;
    check("posClear remaining", position, expPos);

    // 6b. flush while running, with a same-cycle push that must be dropped
    genHold = 1'b1;
    pushSeg(1'b0, 3, 3, 1'b1);
    waitRunEmpty("flush");
    pushSeg(1'b1, 2, 2, 1'b1);
    flush = 1'b1;
    wrIf.wrValid = 1'b1; wrIf.wrDir = 1'b1; wrIf.wrDivider = 15'd2; wrIf.wrSteps = 14'd2;
    @(posedge CLK); #1;
    flush = 1'b0; wrIf.wrValid = 1'b0;
    void'(exp_q.pop_back());
    check("flush fifoCount", fifoCount, 0);
    check("flush running", running, 1);
    genHold = 1'b0;
    waitIdle("flush", 500);
    expPos = expPos - 19'd3;
    check("flush position", position, expPos);
    check("flush segDone", doneSeen - doneBase, 2);

    // mid-operation reset loses the queue
    genHold = 1'b1;
    pushSeg(1'b1, 2, 3, 1'b1);
    pushSeg(1'b1, 2, 3, 1'b0);
    repeat (6) begin @(posedge CLK); #1; end
    check("pre-reset fifoCount", fifoCount, 1);
    nReset = 1'b0;
    #2;
    check("async reset fifoCount", fifoCount, 0);
    check("async reset running", running, 0);
    check("async reset position", position, 0);
    genHold = 1'b0;
    @(negedge CLK); nReset = 1'b1;
    repeat (5) begin @(posedge CLK); #1; end
    check("post-reset idle", running, 0);
    check("scoreboard drained", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
